// File: rtl/dds_pkg.sv
// Shared geometry, types and phase-decode helper for the DDS sine generator.
package dds_pkg;

    localparam int unsigned ACC_W_DEF  = 12;
    localparam int unsigned LUT_AW_DEF = 6;
    localparam int unsigned OUT_W_DEF  = 8;

    typedef logic [ACC_W_DEF-1:0]  phase_t;
    typedef logic [OUT_W_DEF-1:0]  mag_t;
    typedef logic [LUT_AW_DEF-1:0] lut_addr_t;

    // Quarter-wave table address: rising quadrant reads forward, falling quadrant
    // reads the table backwards ((2^LUT_AW-1) - a is just the bitwise complement).
    function automatic lut_addr_t quarter_addr(input phase_t acc);
        lut_addr_t a;
        a = acc[ACC_W_DEF-3 -: LUT_AW_DEF];
        return acc[ACC_W_DEF-2] ? ~a : a;
    endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// Combinational quarter-wave ROM: mag = round(255*sin(pi*addr/128)), addr 0..63.
module dds_quarter_lut
    import dds_pkg::*;
(
    input  lut_addr_t addr_i,
    output mag_t      mag_o
);

    // Constant table lookup; monotonic non-decreasing from 0 up to 255.
    always_comb begin
        mag_o = '0;
        case (addr_i)
            6'd0:  mag_o = 8'd0;   6'd1:  mag_o = 8'd6;   6'd2:  mag_o = 8'd13;  6'd3:  mag_o = 8'd19;
            6'd4:  mag_o = 8'd25;  6'd5:  mag_o = 8'd31;  6'd6:  mag_o = 8'd37;  6'd7:  mag_o = 8'd44;
            6'd8:  mag_o = 8'd50;  6'd9:  mag_o = 8'd56;  6'd10: mag_o = 8'd62;  6'd11: mag_o = 8'd68;
            6'd12: mag_o = 8'd74;  6'd13: mag_o = 8'd80;  6'd14: mag_o = 8'd86;  6'd15: mag_o = 8'd92;
            6'd16: mag_o = 8'd98;  6'd17: mag_o = 8'd103; 6'd18: mag_o = 8'd109; 6'd19: mag_o = 8'd115;
            6'd20: mag_o = 8'd120; 6'd21: mag_o = 8'd126; 6'd22: mag_o = 8'd131; 6'd23: mag_o = 8'd136;
            6'd24: mag_o = 8'd142; 6'd25: mag_o = 8'd147; 6'd26: mag_o = 8'd152; 6'd27: mag_o = 8'd157;
            6'd28: mag_o = 8'd162; 6'd29: mag_o = 8'd167; 6'd30: mag_o = 8'd171; 6'd31: mag_o = 8'd176;
            6'd32: mag_o = 8'd180; 6'd33: mag_o = 8'd185; 6'd34: mag_o = 8'd189; 6'd35: mag_o = 8'd193;
            6'd36: mag_o = 8'd197; 6'd37: mag_o = 8'd201; 6'd38: mag_o = 8'd205; 6'd39: mag_o = 8'd208;
            6'd40: mag_o = 8'd212; 6'd41: mag_o = 8'd215; 6'd42: mag_o = 8'd219; 6'd43: mag_o = 8'd222;
            6'd44: mag_o = 8'd225; 6'd45: mag_o = 8'd228; 6'd46: mag_o = 8'd231; 6'd47: mag_o = 8'd233;
            6'd48: mag_o = 8'd236; 6'd49: mag_o = 8'd238; 6'd50: mag_o = 8'd240; 6'd51: mag_o = 8'd242;
            6'd52: mag_o = 8'd244; 6'd53: mag_o = 8'd246; 6'd54: mag_o = 8'd247; 6'd55: mag_o = 8'd249;
            6'd56: mag_o = 8'd250; 6'd57: mag_o = 8'd251; 6'd58: mag_o = 8'd252; 6'd59: mag_o = 8'd253;
            6'd60: mag_o = 8'd254; 6'd61: mag_o = 8'd254; 6'd62: mag_o = 8'd255; 6'd63: mag_o = 8'd255;
            default: mag_o = '0;
        endcase
    end

endmodule

// File: rtl/dds_sine_gen.sv
// DDS sine generator: FTW register, phase accumulator, quarter-wave ROM and
// registered sign/magnitude output (output lags the accumulator by one clock).
module dds_sine_gen
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned LUT_AW = LUT_AW_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       init,
    input  logic             wr,
    output logic [OUT_W-1:0] out,
    output logic             sym
);

    logic [3:0]        ftw_q, ftw_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              sym_q, sym_d;
    logic [LUT_AW-1:0] lut_a;
    lut_addr_t         lut_addr;
    mag_t              lut_mag;

    // Next-state: FTW load, modulo accumulate with the pre-load FTW, phase decode.
    always_comb begin
        ftw_d    = wr ? init : ftw_q;
        acc_d    = acc_q + ACC_W'(ftw_q);
        lut_a    = acc_q[ACC_W-3 -: LUT_AW];
        // Falling quadrant mirrors the table: (2^LUT_AW-1) - a == ~a.
        lut_addr = acc_q[ACC_W-2] ? ~lut_a : lut_a;
        out_d    = OUT_W'(lut_mag);
        sym_d    = acc_q[ACC_W-1];
    end

    dds_quarter_lut u_lut (
        .addr_i (lut_addr),
        .mag_o  (lut_mag)
    );

    // State registers; everything clears asynchronously and holds while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_q <= '0;
            acc_q <= '0;
            out_q <= '0;
            sym_q <= 1'b0;
        end else begin
            ftw_q <= ftw_d;
            acc_q <= acc_d;
            out_q <= out_d;
            sym_q <= sym_d;
        end
    end

    assign out = out_q;
    assign sym = sym_q;

endmodule

// File: tb/tb_dds_sine_gen.sv
// Self-checking bench for dds_sine_gen against a sine-arithmetic reference model.
module tb_dds_sine_gen;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] init  = '0;
    logic       wr    = 1'b0;
    logic [7:0] out;
    logic       sym;

    int checks = 0;
    int errors = 0;

    // Reference model state: phase, tuning word, expected registered outputs.
    int m_acc  = 0;
    int m_ftw  = 0;
    int m_out  = 0;
    int m_sym  = 0;
    int m_prev = 0;

    always #5 clk = ~clk;

    dds_sine_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (init),
        .wr    (wr),
        .out   (out),
        .sym   (sym)
    );

    function automatic int sine_rom(int idx);
        real v;
        v = 255.0 * $sin(3.14159265358979 * idx / 128.0);
        return $rtoi(v + 0.5);
    endfunction

    // Magnitude from phase: position within the half cycle, 16 phase units per
    // table step, second quarter walks the same curve backwards.
    function automatic int ref_mag(int phase);
        int k;
        k = (phase % 2048) / 16;
        if (k >= 64) k = 127 - k;
        return sine_rom(k);
    endfunction

    task automatic model_reset();
        m_acc = 0; m_ftw = 0; m_out = 0; m_sym = 0; m_prev = 0;
    endtask

    // Advance one clock in DUT and model; returns 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m_prev = m_acc;
            m_out  = ref_mag(m_acc);
            m_sym  = (m_acc >= 2048) ? 1 : 0;
            m_acc  = (m_acc + m_ftw) % 4096;
            if (wr) m_ftw = int'(init);
        end
        #1;
    endtask

    task automatic do_reset();
        wr = 1'b0; init = '0;
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        init = 4'd7; wr = 1'b1;
        tick();
        wr = 1'b0;
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 8'd0 || sym !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out=%0d sym=%0b, expected out=0 sym=0", out, sym);
        end
        model_reset();
        tick();
        checks++;
        if (out !== 8'd0 || sym !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: out=%0d sym=%0b, expected out=0 sym=0", out, sym);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (out !== 8'(m_out) || sym !== 1'(m_sym)) begin
                errors++;
                $display("FAIL reset_release cyc %0d: out=%0d sym=%0b, expected out=%0d sym=%0d",
                         i, out, sym, m_out, m_sym);
            end
        end
    endtask

    task automatic test_load_step();
        int   rise0 = -1;
        int   rise1 = -1;
        int   fall0 = -1;
        logic last  = 1'b0;
        do_reset();
        init = 4'd8; wr = 1'b1;
        tick();
        wr = 1'b0; init = 4'd3;
        for (int i = 0; i < 1100; i++) begin
            tick();
            checks++;
            if (out !== 8'(m_out) || sym !== 1'(m_sym)) begin
                errors++;
                $display("FAIL load_step cyc %0d: out=%0d sym=%0b, expected out=%0d sym=%0d",
                         i, out, sym, m_out, m_sym);
            end
            if (m_prev == 512) begin
                checks++;
                if (out !== 8'd180 || sym !== 1'b0) begin
                    errors++;
                    $display("FAIL step_acc512: out=%0d sym=%0b, expected out=180 sym=0", out, sym);
                end
            end
            if (m_prev == 1024) begin
                checks++;
                if (out !== 8'd255) begin
                    errors++;
                    $display("FAIL step_acc1024: out=%0d, expected 255", out);
                end
            end
            if (sym && !last) begin
                if (rise0 < 0) rise0 = i;
                else if (rise1 < 0) rise1 = i;
            end
            if (!sym && last && rise0 >= 0 && fall0 < 0) fall0 = i;
            last = sym;
        end
        checks++;
        if (fall0 - rise0 != 256) begin
            errors++;
            $display("FAIL half_period: sym high %0d clocks, expected 256", fall0 - rise0);
        end
        checks++;
        if (rise1 - rise0 != 512) begin
            errors++;
            $display("FAIL full_period: period %0d clocks, expected 512", rise1 - rise0);
        end
    endtask

    task automatic test_zero_ftw();
        do_reset();
        init = 4'd0; wr = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (out !== 8'd0 || sym !== 1'b0) begin
                errors++;
                $display("FAIL zero_after_reset cyc %0d: out=%0d sym=%0b, expected 0/0",
                         i, out, sym);
            end
        end
        init = 4'd9;
        repeat (150) tick();
        init = 4'd0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (out !== 8'(m_out) || sym !== 1'(m_sym)) begin
                errors++;
                $display("FAIL zero_frozen cyc %0d: out=%0d sym=%0b, expected out=%0d sym=%0d",
                         i, out, sym, m_out, m_sym);
            end
        end
    endtask

    task automatic test_continuous();
        int   r1 = -1;
        int   r2 = -1;
        int   r3 = -1;
        logic last = 1'b0;
        do_reset();
        wr = 1'b1; init = 4'd15;
        for (int i = 0; i < 600; i++) begin
            tick();
            checks++;
            if (out !== 8'(m_out) || sym !== 1'(m_sym)) begin
                errors++;
                $display("FAIL cont_ftw15 cyc %0d: out=%0d sym=%0b, expected out=%0d sym=%0d",
                         i, out, sym, m_out, m_sym);
            end
            if (sym && !last) begin
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
            end
            last = sym;
        end
        checks++;
        if (r2 - r1 < 273 || r2 - r1 > 274) begin
            errors++;
            $display("FAIL period_ftw15: %0d clocks, expected 273..274", r2 - r1);
        end
        init = 4'd5;
        r1 = -1; r2 = -1;
        for (int i = 0; i < 2600; i++) begin
            tick();
            checks++;
            if (out !== 8'(m_out) || sym !== 1'(m_sym)) begin
                errors++;
                $display("FAIL cont_ftw5 cyc %0d: out=%0d sym=%0b, expected out=%0d sym=%0d",
                         i, out, sym, m_out, m_sym);
            end
            if (sym && !last) begin
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i; else if (r3 < 0) r3 = i;
            end
            last = sym;
        end
        checks++;
        if (r3 - r2 < 819 || r3 - r2 > 820) begin
            errors++;
            $display("FAIL period_ftw5: %0d clocks, expected 819..820", r3 - r2);
        end
    endtask

    task automatic test_table();
        int seq[128];
        for (int k = 0; k < 128; k++) seq[k] = -1;
        do_reset();
        init = 4'd1; wr = 1'b1;
        tick();
        wr = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            tick();
            checks++;
            if (out !== 8'(m_out) || sym !== 1'b0) begin
                errors++;
                $display("FAIL table_walk cyc %0d: out=%0d sym=%0b, expected out=%0d sym=0",
                         i, out, sym, m_out);
            end
            if (m_prev % 16 == 0 && m_prev < 2048) seq[m_prev / 16] = int'(out);
        end
        for (int k = 0; k < 128; k++) begin
            int idx;
            idx = (k < 64) ? k : 127 - k;
            checks++;
            if (seq[k] != sine_rom(idx)) begin
                errors++;
                $display("FAIL table_entry %0d: out=%0d, expected %0d", k, seq[k], sine_rom(idx));
            end
        end
        checks++;
        if (seq[0] != 0 || seq[16] != 98 || seq[32] != 180 || seq[63] != 255) begin
            errors++;
            $display("FAIL table_fixed: [0]=%0d [16]=%0d [32]=%0d [63]=%0d, expected 0 98 180 255",
                     seq[0], seq[16], seq[32], seq[63]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            wr   = ($urandom_range(0, 7) == 0);
            init = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (out !== 8'(m_out) || sym !== 1'(m_sym)) begin
                errors++;
                $display("FAIL random cyc %0d: out=%0d sym=%0b, expected out=%0d sym=%0d",
                         i, out, sym, m_out, m_sym);
            end
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (out !== 8'd0 || sym !== 1'b0) begin
                    errors++;
                    $display("FAIL random_reset cyc %0d: out=%0d sym=%0b, expected 0/0",
                             i, out, sym);
                end
                model_reset();
                #1;
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_load_step();
        test_zero_ftw();
        test_continuous();
        test_table();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
